// File: rtl/bit_scan_locator.sv
// bit_scan_locator: sequential set-bit locator.
// A word is accepted over a valid/ready handshake and shifted right one bit
// per clock. Find-first mode reports only the lowest set bit. Enumerate mode
// reports every set bit, LSB first. An all-zero word yields a single result
// with location WIDTH and the zero flag set.
module bit_scan_locator #(
   parameter int WIDTH = 8,
   parameter int LOCW  = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LOCW-1:0]  out_loc,
   output logic             out_zero,
   output logic             out_last,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      EMIT = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sh;       // remaining bits of the word, current bit at [0]
   logic [LOCW-1:0]  cnt;      // bit index of sh[0] within the original word
   logic             mode;     // 0 = find-first, 1 = enumerate
   logic [WIDTH-1:0] sh_next;  // word after dropping the current bit

   // Shifted word, shared by the SCAN step and the EMIT-to-SCAN step.
   assign sh_next = sh >> 1;

   // Single FSM: state, datapath and every output are registered together,
   // so in_ready/busy/out_valid always agree with the current state.
   always_ff @(posedge clk) begin
      // NOTE: every register here uses non-blocking assignment so all
      // decisions in one edge see the pre-edge values of sh, cnt and state.
      if (reset) begin
         state     <= IDLE;
         sh        <= '0;
         cnt       <= '0;
         mode      <= 1'b0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_loc   <= '0;
         out_zero  <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sh       <= in_data;
                  cnt      <= '0;
                  mode     <= in_mode;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (in_data == '0) begin
                     // Nothing to scan: report the zero word immediately.
                     state     <= EMIT;
                     out_valid <= 1'b1;
                     out_loc   <= LOCW'(WIDTH);
                     out_zero  <= 1'b1;
                     out_last  <= 1'b1;
                  end else begin
                     state <= SCAN;
                  end
               end
            end

            SCAN: begin
               // sh is nonzero here, so a set bit is reached within WIDTH
               // edges and cnt stays below WIDTH.
               if (sh[0]) begin
                  state     <= EMIT;
                  out_valid <= 1'b1;
                  out_loc   <= cnt;
                  out_zero  <= 1'b0;
                  out_last  <= !mode || (sh_next == '0);
               end else begin
                  sh  <= sh_next;
                  cnt <= cnt + LOCW'(1);
               end
            end

            EMIT: begin
               // Result is held until the consumer takes it.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (out_last) begin
                     state    <= IDLE;
                     in_ready <= 1'b1;
                     busy     <= 1'b0;
                  end else begin
                     state <= SCAN;
                     sh    <= sh_next;
                     cnt   <= cnt + LOCW'(1);
                  end
               end
            end

            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bit_scan_locator.sv
// Testbench for bit_scan_locator: one WIDTH=8 and one WIDTH=32 instance.
// A transaction-level model (remaining set-bit mask plus a countdown to the
// next result) predicts the outputs; a negedge process compares every cycle.
module tb_bit_scan_locator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Index 0 drives the WIDTH=8 instance, index 1 the WIDTH=32 instance.
   logic        reset     [2];
   logic        in_valid  [2];
   logic        in_mode   [2];
   logic        out_ready [2];
   logic [31:0] in_data   [2];
   logic        in_ready  [2];
   logic        out_valid [2];
   logic        out_zero  [2];
   logic        out_last  [2];
   logic        busy      [2];
   logic [3:0]  loc8;
   logic [5:0]  loc32;

   int n_checks = 0;
   int n_errors = 0;

   bit_scan_locator #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .reset     (reset[0]),
      .in_valid  (in_valid[0]),
      .in_ready  (in_ready[0]),
      .in_data   (in_data[0][7:0]),
      .in_mode   (in_mode[0]),
      .out_valid (out_valid[0]),
      .out_ready (out_ready[0]),
      .out_loc   (loc8),
      .out_zero  (out_zero[0]),
      .out_last  (out_last[0]),
      .busy      (busy[0])
   );

   bit_scan_locator #(.WIDTH(32)) dut32 (
      .clk       (clk),
      .reset     (reset[1]),
      .in_valid  (in_valid[1]),
      .in_ready  (in_ready[1]),
      .in_data   (in_data[1]),
      .in_mode   (in_mode[1]),
      .out_valid (out_valid[1]),
      .out_ready (out_ready[1]),
      .out_loc   (loc32),
      .out_zero  (out_zero[1]),
      .out_last  (out_last[1]),
      .busy      (busy[1])
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int wid(input int i);
      return (i == 0) ? 8 : 32;
   endfunction

   function automatic logic [63:0] loc_of(input int i);
      return (i == 0) ? 64'(loc8) : 64'(loc32);
   endfunction

   function automatic int lowest(input logic [31:0] v);
      int r = -1;
      for (int b = 31; b >= 0; b--) if (v[b]) r = b;
      return r;
   endfunction

   // ---------------- behavioural model ----------------
   bit          m_act      [2] = '{0, 0};
   bit          m_v        [2] = '{0, 0};
   bit          m_zero     [2] = '{0, 0};
   bit          m_last     [2] = '{0, 0};
   bit          m_mode     [2] = '{0, 0};
   bit          m_just_rst [2] = '{0, 0};
   int          m_loc      [2] = '{0, 0};
   int          m_prev     [2] = '{0, 0};
   int          m_wait     [2] = '{0, 0};
   logic [31:0] m_rem      [2] = '{32'h0, 32'h0};

   // One edge of the model: a result for set bit q appears (q - previous bit)
   // edges after the accept or the preceding handshake; previous bit starts at -1.
   task automatic model_step(input int i);
      logic [31:0] mask;
      logic [31:0] w;
      int          p;
      mask = (i == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
      m_just_rst[i] = 1'b0;
      if (reset[i]) begin
         m_act[i] = 0; m_v[i] = 0; m_loc[i] = 0; m_zero[i] = 0; m_last[i] = 0;
         m_just_rst[i] = 1'b1;
      end else if (!m_act[i]) begin
         if (in_valid[i]) begin
            w = in_data[i] & mask;
            m_act[i] = 1'b1;
            if (w == 32'h0) begin
               m_v[i] = 1; m_loc[i] = wid(i); m_zero[i] = 1; m_last[i] = 1;
            end else begin
               m_rem[i]  = w;
               m_mode[i] = in_mode[i];
               m_prev[i] = -1;
               m_wait[i] = lowest(w) + 1;
            end
         end
      end else if (!m_v[i]) begin
         m_wait[i]--;
         if (m_wait[i] == 0) begin
            p = lowest(m_rem[i]);
            m_rem[i][p] = 1'b0;
            m_loc[i]  = p;
            m_prev[i] = p;
            m_zero[i] = 1'b0;
            m_last[i] = !m_mode[i] || (m_rem[i] == 32'h0);
            m_v[i]    = 1'b1;
         end
      end else if (out_ready[i]) begin
         m_v[i] = 1'b0;
         if (m_last[i]) m_act[i] = 1'b0;
         else m_wait[i] = lowest(m_rem[i]) - m_prev[i];
      end
   endtask

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) model_step(i);
   end

   // Compare DUT against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         check($sformatf("w%0d out_valid", wid(i)), 64'(out_valid[i]), 64'(m_v[i]));
         check($sformatf("w%0d in_ready", wid(i)), 64'(in_ready[i]), 64'(!m_act[i]));
         check($sformatf("w%0d busy", wid(i)), 64'(busy[i]), 64'(m_act[i]));
         if (m_v[i] || m_just_rst[i]) begin
            check($sformatf("w%0d out_loc", wid(i)), loc_of(i), 64'(m_loc[i]));
            check($sformatf("w%0d out_zero", wid(i)), 64'(out_zero[i]), 64'(m_zero[i]));
            check($sformatf("w%0d out_last", wid(i)), 64'(out_last[i]), 64'(m_last[i]));
         end
      end
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic offer(input int i, input logic [31:0] d, input logic m);
      int n = 0;
      while (!in_ready[i] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("offer timeout", 64'd0, 64'd1);
      in_valid[i] = 1'b1;
      in_data[i]  = d;
      in_mode[i]  = m;
      @(negedge clk);
      in_valid[i] = 1'b0;
   endtask

   // Latency counted in edges after the accept edge.
   task automatic wait_valid(input int i, output int lat);
      lat = 0;
      while (!out_valid[i] && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 100) check("out_valid timeout", 64'd0, 64'd1);
   endtask

   task automatic take(input int i);
      out_ready[i] = 1'b1;
      @(negedge clk);
      out_ready[i] = 1'b0;
   endtask

   task automatic single(input int i, input logic [31:0] d, input logic m,
                         input int exp_lat, input int exp_loc, input bit exp_zero);
      int lat;
      offer(i, d, m);
      wait_valid(i, lat);
      check($sformatf("w%0d lat %0h", wid(i), d), 64'(lat), 64'(exp_lat));
      check($sformatf("w%0d loc %0h", wid(i), d), loc_of(i), 64'(exp_loc));
      check($sformatf("w%0d zero %0h", wid(i), d), 64'(out_zero[i]), 64'(exp_zero));
      check($sformatf("w%0d last %0h", wid(i), d), 64'(out_last[i]), 64'd1);
      take(i);
   endtask

   function automatic logic [31:0] rand_word();
      case ($urandom % 4)
         0:       return 32'h0;
         1:       return 32'h1 << ($urandom % 32);
         2:       return $urandom;
         default: return $urandom & $urandom & $urandom;
      endcase
   endfunction

   initial begin
      int lat;
      int idx;
      int n;
      int seen;
      int exp_a5 [4];
      int exp_5a [4];
      exp_a5 = '{0, 2, 5, 7};
      exp_5a = '{1, 3, 4, 6};
      for (int i = 0; i < 2; i++) begin
         reset[i] = 1'b1; in_valid[i] = 1'b0; in_data[i] = '0;
         in_mode[i] = 1'b0; out_ready[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
      reset[0] = 1'b0;
      reset[1] = 1'b0;

      // Pin the model's bit search.
      check("model lowest a0", 64'(lowest(32'h0000_00A0)), 64'd5);
      check("model lowest msb", 64'(lowest(32'h8000_0000)), 64'd31);

      // Reset values.
      check("rst in_ready", 64'(in_ready[0]), 64'd1);
      check("rst busy", 64'(busy[0]), 64'd0);
      check("rst out_valid", 64'(out_valid[0]), 64'd0);
      check("rst out_loc", loc_of(0), 64'd0);
      check("rst out_last", 64'(out_last[0]), 64'd0);

      // Find-first and zero words, WIDTH=8.
      single(0, 32'h03, 1'b0, 1, 0, 1'b0);
      single(0, 32'h80, 1'b0, 8, 7, 1'b0);
      single(0, 32'h04, 1'b0, 3, 2, 1'b0);
      single(0, 32'h00, 1'b0, 0, 8, 1'b1);
      single(0, 32'h00, 1'b1, 0, 8, 1'b1);

      // Enumerate 1010_0101 with out_ready held high.
      offer(0, 32'hA5, 1'b1);
      out_ready[0] = 1'b1;
      idx = 0; n = 0; seen = 0;
      while (!seen && n < 60) begin
         if (out_valid[0]) begin
            if (idx < 4) begin
               check("enum a5 loc", loc_of(0), 64'(exp_a5[idx]));
               check("enum a5 last", 64'(out_last[0]), 64'(idx == 3));
            end else check("enum a5 extra result", 64'(idx), 64'd3);
            if (out_last[0]) seen = 1;
            idx++;
         end
         @(negedge clk);
         n++;
      end
      out_ready[0] = 1'b0;
      check("enum a5 count", 64'(idx), 64'd4);
      check("enum a5 idle after", 64'(in_ready[0]), 64'd1);

      // Enumerate 0101_1010 with 5-cycle stalls and in_valid pulses while busy.
      offer(0, 32'h5A, 1'b1);
      for (int r = 0; r < 4; r++) begin
         wait_valid(0, lat);
         for (int s = 0; s < 5; s++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = $urandom;
            in_mode[0]  = 1'($urandom % 2);
            @(negedge clk);
            check("stall loc", loc_of(0), 64'(exp_5a[r]));
            check("stall last", 64'(out_last[0]), 64'(r == 3));
         end
         in_valid[0] = 1'b0;
         take(0);
      end
      check("stall idle after", 64'(in_ready[0]), 64'd1);

      // WIDTH=32: reset while scanning toward bit 31 abandons the word.
      offer(1, 32'h8000_0001, 1'b1);
      wait_valid(1, lat);
      check("w32 first lat", 64'(lat), 64'd1);
      check("w32 first loc", loc_of(1), 64'd0);
      check("w32 first last", 64'(out_last[1]), 64'd0);
      take(1);
      repeat (10) @(negedge clk);
      reset[1] = 1'b1;
      @(negedge clk);
      reset[1] = 1'b0;
      check("w32 rst out_valid", 64'(out_valid[1]), 64'd0);
      check("w32 rst out_loc", loc_of(1), 64'd0);
      check("w32 rst busy", 64'(busy[1]), 64'd0);
      check("w32 rst in_ready", 64'(in_ready[1]), 64'd1);
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (out_valid[1]) seen++;
         @(negedge clk);
      end
      check("w32 no result after reset", 64'(seen), 64'd0);
      single(1, 32'h10, 1'b0, 5, 4, 1'b0);

      // Randomized traffic on both instances; the model checks every cycle.
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < 2; i++) begin
            in_valid[i]  = ($urandom % 3) == 0;
            in_data[i]   = rand_word();
            in_mode[i]   = 1'($urandom % 2);
            out_ready[i] = ($urandom % 3) != 0;
            reset[i]     = ($urandom % 400) == 0;
         end
         @(negedge clk);
      end
      for (int i = 0; i < 2; i++) begin
         reset[i] = 1'b0; in_valid[i] = 1'b0; out_ready[i] = 1'b1;
      end
      repeat (80) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
